register_file: RTL and testbench

//   RISC-V integer register file: 32 x N-bit registers, two read ports, one write port.

---
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// RISC-V integer register file: 31 stored N-bit registers (x0 hard-wired to zero),
// two asynchronous read ports with optional same-cycle write forwarding, one write port.
module register_file #(
    parameter int unsigned N      = 64,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   rs1_addr,
    input  logic [4:0]   rs2_addr,
    input  logic [4:0]   rd_addr,
    input  logic [N-1:0] rd_data,
    input  logic         rd_we,
    output logic [N-1:0] rs1_data,
    output logic [N-1:0] rs2_data
);

    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    logic [N-1:0] regs_q [1:NREG-1];
    logic [N-1:0] regs_d [1:NREG-1];

    logic wr_en;
    logic fwd_en;

    // x0 has no storage, so a write to it simply selects nothing
    assign wr_en  = rd_we && (rd_addr != '0);
    // reset wins over a write, so nothing is forwarded while rst is high
    assign fwd_en = BYPASS && wr_en && !rst;

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (wr_en && (rd_addr == AW'(i))) begin
                regs_d[i] = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: array mux, x0 falls through to zero, then optional forward
    always_comb begin
        rs1_data = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (rs1_addr == AW'(i)) begin
                rs1_data = regs_q[i];
            end
        end
        if (fwd_en && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
        end
    end

    // Read port 2: identical structure, fully independent of port 1
    always_comb begin
        rs2_data = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (rs2_addr == AW'(i)) begin
                rs2_data = regs_q[i];
            end
        end
        if (fwd_en && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a forwarding and a non-forwarding instance
// share one stimulus stream; per-cycle expectations go through a scoreboard queue.
module tb_register_file;

    localparam int unsigned N = 64;

    typedef struct {
        string       name;
        bit          rst;
        bit          we;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] n1;
        logic [63:0] n2;
        bit          chk;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [63:0] n1;
        logic [63:0] n2;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [4:0]   rd_addr;
    logic [N-1:0] rd_data;
    logic         rd_we;
    logic [N-1:0] rs1_b, rs2_b, rs1_n, rs2_n;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    exp_t sb[$];

    register_file #(.N(N), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
        .rs1_data(rs1_b), .rs2_data(rs2_b)
    );

    register_file #(.N(N), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
        .rs1_data(rs1_n), .rs2_data(rs2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, bit r, bit we, logic [4:0] rd, logic [63:0] d,
                                logic [4:0] a1, logic [4:0] a2,
                                logic [63:0] e1, logic [63:0] e2,
                                logic [63:0] n1, logic [63:0] n2, bit chk);
        vec_t v;
        v.name = nm; v.rst = r; v.we = we; v.rd = rd; v.data = d;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.n1 = n1; v.n2 = n2; v.chk = chk;
        return v;
    endfunction

    task automatic cmp(string nm, string port, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got=%h exp=%h", nm, port, got, exp);
        end
    endtask

    // Drive one cycle mid-period, push its expectation, sample before the next rising edge
    task automatic apply(vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; rd_we = v.we; rd_addr = v.rd; rd_data = v.data;
        rs1_addr = v.a1; rs2_addr = v.a2;
        if (v.chk) begin
            e.name = v.name; e.e1 = v.e1; e.e2 = v.e2; e.n1 = v.n1; e.n2 = v.n2;
            sb.push_back(e);
        end
        #2;
        if (v.chk) begin
            e = sb.pop_front();
            cmp(e.name, "byp.rs1", rs1_b, e.e1);
            cmp(e.name, "byp.rs2", rs2_b, e.e2);
            cmp(e.name, "nb.rs1",  rs1_n, e.n1);
            cmp(e.name, "nb.rs2",  rs2_n, e.n2);
        end
    endtask

    initial begin
        logic [63:0] dead;
        logic [63:0] ones;
        dead = 64'hDEAD_BEEF_0123_4567;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b1; rd_we = 1'b0; rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0;

        // Reset, then every address on both ports reads zero
        vecs.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk("rst_read", 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 1));

        // Write x5, then read it back on both ports
        vecs.push_back(mk("wr_x5", 0, 1, 5, dead, 0, 5, 0, dead, 0, 0, 1));
        vecs.push_back(mk("rd_x5", 0, 0, 0, 0, 5, 5, dead, dead, dead, dead, 1));

        // x0 write is ignored and never forwarded; x5 is untouched
        vecs.push_back(mk("wr_x0", 0, 1, 0, ones, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rd_x0", 0, 0, 0, 0, 0, 5, 0, dead, 0, dead, 1));

        // Same-cycle forward on both ports
        vecs.push_back(mk("wr_x7_1", 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("byp_x7", 0, 1, 7, 2, 7, 7, 2, 2, 1, 1, 1));
        vecs.push_back(mk("rd_x7", 0, 0, 0, 0, 7, 7, 2, 2, 2, 2, 1));

        // Reset beats a write in the same cycle and shows no forwarding
        vecs.push_back(mk("wr_x3_9", 0, 1, 3, 9, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("rst_wr", 1, 1, 3, 5, 3, 7, 9, 2, 9, 2, 1));
        vecs.push_back(mk("post_rst", 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 1));

        // Sweep writes with forwarding visible on port 1 and the previous register on port 2
        for (int i = 1; i < 32; i++)
            vecs.push_back(mk("sweep_wr", 0, 1, 5'(i), 64'(i * 3), 5'(i), 5'(i - 1),
                              64'(i * 3), 64'((i - 1) * 3), 0, 64'((i - 1) * 3), 1));
        for (int i = 1; i < 32; i++)
            vecs.push_back(mk("sweep_rd", 0, 0, 0, 0, 5'(i), 5'(32 - i),
                              64'(i * 3), 64'((32 - i) * 3), 64'(i * 3), 64'((32 - i) * 3), 1));

        foreach (vecs[k]) apply(vecs[k]);

        // Hand sequence: a reset between writes clears everything written before it
        apply(mk("seq_wr_a", 0, 1, 31, ones, 31, 0, ones, 0, 93, 0, 1));
        apply(mk("seq_rst", 1, 0, 0, 0, 31, 1, ones, 3, ones, 3, 1));
        apply(mk("seq_wr_b", 0, 1, 2, 64'h55, 31, 2, 0, 64'h55, 0, 0, 1));
        apply(mk("seq_rd", 0, 0, 0, 0, 2, 31, 64'h55, 0, 64'h55, 0, 1));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
